instruction_fetch_unit: RTL



---
 rtl/instruction_fetch_unit_pkg.sv | 23 ++
 rtl/pc_register.sv | 21 ++
 rtl/instruction_fetch_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package instruction_fetch_unit_pkg;

  // Default PC loaded on reset.
  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  // Default instruction word placed in IF/ID on flush or reset.
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;
  // Sequential fetch stride in bytes.
  localparam logic [31:0] PC_INC            = 32'h0000_0004;
  // Clears the byte-offset bits of a redirect target.
  localparam logic [31:0] ALIGN_MASK        = 32'hFFFF_FFFC;

  typedef enum logic {
    StRun    = 1'b0,
    StHalted = 1'b1
  } fetch_state_e;

  // A redirect target is misaligned when either byte-offset bit is set.
  function automatic logic is_misaligned(input logic [31:0] target);
    return |target[1:0];
  endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter flop with load enable and asynchronous active-low reset.
module pc_register #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        load_en,
  input  logic [31:0] next_pc,
  output logic [31:0] pc
);

  // Holds unless the fetch logic asks for a new PC.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc <= RESET_PC;
    end else if (load_en) begin
      pc <= next_pc;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: PC, next-PC priority selection, IF/ID register, halt FSM, fetch counter.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR     = DEFAULT_NOP_INSTR,
  parameter bit          FLUSH_ON_JUMP = 1'b1,
  parameter int unsigned COUNT_W       = 32
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [31:0]        Instruction,
  output logic [31:0]        IMAddress,
  input  logic               Stall,
  input  logic               JumpTaken,
  input  logic [31:0]        JumpTarget,
  input  logic               BranchTaken,
  input  logic [31:0]        BranchTarget,
  input  logic               Halt,
  output logic [31:0]        IFID_Instruction,
  output logic [31:0]        IFID_PCPlus4,
  output logic               IFID_Valid,
  output logic               Misaligned,
  output logic [COUNT_W-1:0] FetchCount
);

  fetch_state_e state_q, state_d;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        pc_load;
  logic        ifid_load;
  logic        ifid_flush;
  logic        mis_set;
  logic        halting;

  assign pc_plus4  = pc + PC_INC;
  assign IMAddress = pc;

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .Clk     (Clk),
    .Reset   (Reset),
    .load_en (pc_load),
    .next_pc (next_pc),
    .pc      (pc)
  );

  // Fetch state register; only reset leaves the halted state.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and next-PC / IF/ID control in redirect priority order.
  always_comb begin
    state_d    = state_q;
    pc_load    = 1'b0;
    next_pc    = pc;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    mis_set    = 1'b0;
    // The edge that sees Halt already behaves as halted.
    halting    = (state_q == StHalted) || Halt;

    if (Halt) begin
      state_d = StHalted;
    end

    if (BranchTaken) begin
      // Branch is older than anything in IF/ID, so it wins over stall, jump and halt.
      pc_load    = 1'b1;
      next_pc    = BranchTarget & ALIGN_MASK;
      mis_set    = is_misaligned(BranchTarget);
      ifid_flush = 1'b1;
    end else if (JumpTaken && !Stall && !halting) begin
      pc_load = 1'b1;
      next_pc = JumpTarget & ALIGN_MASK;
      mis_set = is_misaligned(JumpTarget);
      if (FLUSH_ON_JUMP) begin
        ifid_flush = 1'b1;
      end else begin
        ifid_load = 1'b1;
      end
    end else if (Stall) begin
      // Hold everything; a stalled jump is re-asserted by ID later.
    end else if (halting) begin
      ifid_flush = 1'b1;
    end else begin
      pc_load   = 1'b1;
      next_pc   = pc_plus4;
      ifid_load = 1'b1;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      IFID_Instruction <= NOP_INSTR;
      IFID_PCPlus4     <= 32'h0;
      IFID_Valid       <= 1'b0;
    end else if (ifid_flush) begin
      IFID_Instruction <= NOP_INSTR;
      IFID_PCPlus4     <= 32'h0;
      IFID_Valid       <= 1'b0;
    end else if (ifid_load) begin
      IFID_Instruction <= Instruction;
      IFID_PCPlus4     <= pc_plus4;
      IFID_Valid       <= 1'b1;
    end
  end

  // Sticky misaligned-redirect flag.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Misaligned <= 1'b0;
    end else if (mis_set) begin
      Misaligned <= 1'b1;
    end
  end

  // Saturating count of valid instructions loaded into IF/ID.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      FetchCount <= '0;
    end else if (ifid_load && (FetchCount != {COUNT_W{1'b1}})) begin
      FetchCount <= FetchCount + COUNT_W'(1);
    end
  end

endmodule
